control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 39 +++
 rtl/control_sequencer.sv | 176 +++++++++++++++++
 tb/tb_control_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction input, halt request and control-word outputs of the control sequencer
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout;
    logic        Zlowout;
    logic        Zhighout;
    logic        MDRout;
    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        LOin;
    logic        HIin;
    logic        IncPC;
    logic        Read;
    logic [3:0]  Rsel;
    logic        Rin;
    logic        Rout;
    logic [4:0]  operation;
    logic        Run;
    logic        Err;

    modport master (
        input  IR, Stop,
        output PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
               Yin, Zin, LOin, HIin, IncPC, Read, Rsel, Rin, Rout, operation,
               Run, Err
    );

    modport slave (
        output IR, Stop,
        input  PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
               Yin, Zin, LOin, HIin, IncPC, Read, Rsel, Rin, Rout, operation,
               Run, Err
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control sequencer, optional mul/div sequencing under MULDIV_EN
module control_sequencer (
    input  logic                Clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    state_t     state_q, state_d;
    logic       err_q, err_d;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_bin, is_un, is_nop, is_halt, is_md;

    assign opcode  = bus.IR[31:27];
    assign ra      = bus.IR[26:23];
    assign rb      = bus.IR[22:19];
    assign rc      = bus.IR[18:15];
    assign is_bin  = (opcode <= 5'd12);
    assign is_un   = (opcode == 5'd17) || (opcode == 5'd18);
    assign is_nop  = (opcode == 5'd26);
    assign is_halt = (opcode == 5'd27);
`ifdef MULDIV_EN
    assign is_md   = (opcode == 5'd15) || (opcode == 5'd16);
`else
    assign is_md   = 1'b0;
`endif

    // Next-state and error-flag logic; illegal opcodes latch Err on the way into HALT
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            T0:   state_d = bus.Stop ? HALT : T1;
            T1:   state_d = T2;
            T2:   state_d = T3;
            T3: begin
                if (is_bin || is_un || is_md) begin
                    state_d = T4;
                end else if (is_nop) begin
                    state_d = T0;
                end else if (is_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end
            end
            T4:   state_d = (is_bin || is_md) ? T5 : T0;
            T5:   state_d = is_md ? T6 : T0;
            T6:   state_d = T0;
            HALT: state_d = HALT;
            default: state_d = T0;
        endcase
    end

    // State and error registers, cleared asynchronously
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= T0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Control word decoded from present state and IR; enables are gated off while
    // clear is high so an abandoned instruction cannot emit a stray load or write
    always_comb begin
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.MDRout    = 1'b0;
        bus.MARin     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.LOin      = 1'b0;
        bus.HIin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.Rsel      = 4'd0;
        bus.Rin       = 1'b0;
        bus.Rout      = 1'b0;
        bus.operation = 5'd0;
        bus.Run       = (state_q != HALT);
        bus.Err       = err_q;
        case (state_q)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                if (is_bin || is_md) begin
                    bus.Rsel = rb;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end else if (is_un) begin
                    bus.Rsel      = rb;
                    bus.Rout      = 1'b1;
                    bus.Zin       = 1'b1;
                    bus.operation = opcode;
                end
            end
            T4: begin
                if (is_bin || is_md) begin
                    bus.Rsel      = rc;
                    bus.Rout      = 1'b1;
                    bus.Zin       = 1'b1;
                    bus.operation = opcode;
                end else if (is_un) begin
                    bus.Zlowout = 1'b1;
                    bus.Rsel    = ra;
                    bus.Rin     = 1'b1;
                end
            end
            T5: begin
                if (is_bin) begin
                    bus.Zlowout = 1'b1;
                    bus.Rsel    = ra;
                    bus.Rin     = 1'b1;
                end
`ifdef MULDIV_EN
                else if (is_md) begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = 1'b1;
                end
`endif
            end
            T6: begin
`ifdef MULDIV_EN
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
`endif
            end
            default: ;
        endcase
        if (clear) begin
            bus.PCout     = 1'b0;
            bus.Zlowout   = 1'b0;
            bus.Zhighout  = 1'b0;
            bus.MDRout    = 1'b0;
            bus.MARin     = 1'b0;
            bus.PCin      = 1'b0;
            bus.MDRin     = 1'b0;
            bus.IRin      = 1'b0;
            bus.Yin       = 1'b0;
            bus.Zin       = 1'b0;
            bus.LOin      = 1'b0;
            bus.HIin      = 1'b0;
            bus.IncPC     = 1'b0;
            bus.Read      = 1'b0;
            bus.Rsel      = 4'd0;
            bus.Rin       = 1'b0;
            bus.Rout      = 1'b0;
            bus.operation = 5'd0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table-driven check of control_sequencer control words
module tb_control_sequencer;

    logic Clock;
    logic clear;
    control_sequencer_if bus ();

    control_sequencer dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [15:0] M_PCOUT  = 16'h8000;
    localparam logic [15:0] M_ZLO    = 16'h4000;
    localparam logic [15:0] M_ZHI    = 16'h2000;
    localparam logic [15:0] M_MDROUT = 16'h1000;
    localparam logic [15:0] M_MARIN  = 16'h0800;
    localparam logic [15:0] M_PCIN   = 16'h0400;
    localparam logic [15:0] M_MDRIN  = 16'h0200;
    localparam logic [15:0] M_IRIN   = 16'h0100;
    localparam logic [15:0] M_YIN    = 16'h0080;
    localparam logic [15:0] M_ZIN    = 16'h0040;
    localparam logic [15:0] M_LOIN   = 16'h0020;
    localparam logic [15:0] M_HIIN   = 16'h0010;
    localparam logic [15:0] M_INCPC  = 16'h0008;
    localparam logic [15:0] M_READ   = 16'h0004;
    localparam logic [15:0] M_RIN    = 16'h0002;
    localparam logic [15:0] M_ROUT   = 16'h0001;
    localparam logic [15:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [15:0] F1 = M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [15:0] F2 = M_MDROUT | M_IRIN;

    logic [15:0] en_act;
    logic [26:0] word_act;
    assign en_act = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout,
                     bus.MARin, bus.PCin, bus.MDRin, bus.IRin,
                     bus.Yin, bus.Zin, bus.LOin, bus.HIin,
                     bus.IncPC, bus.Read, bus.Rin, bus.Rout};
    assign word_act = {en_act, bus.Rsel, bus.operation, bus.Run, bus.Err};

    typedef struct {
        logic [31:0] ir;
        logic        stop;
        logic        clr;
        logic [15:0] en;
        logic [3:0]  rsel;
        logic [4:0]  op;
        logic        run;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    function automatic void add(logic [31:0] ir, logic stop, logic clr, logic [15:0] en,
                                logic [3:0] rsel, logic [4:0] op, logic run, logic err);
        vec_t v;
        v.ir = ir; v.stop = stop; v.clr = clr; v.en = en;
        v.rsel = rsel; v.op = op; v.run = run; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fetch(logic [31:0] ir);
        add(ir, 1'b0, 1'b1, F0, 4'd0, 5'd0, 1'b1, 1'b0);
        add(ir, 1'b0, 1'b0, F1, 4'd0, 5'd0, 1'b1, 1'b0);
        add(ir, 1'b0, 1'b0, F2, 4'd0, 5'd0, 1'b1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear    = 1'b1;
        bus.IR   = 32'h0;
        bus.Stop = 1'b0;

        // and R4,R3,R7: 6 cycles, T0 again on cycle 7
        fetch(32'h3A1B8000);
        add(32'h3A1B8000, 0, 0, M_ROUT | M_YIN, 4'd3, 5'd0, 1, 0);
        add(32'h3A1B8000, 0, 0, M_ROUT | M_ZIN, 4'd7, 5'd7, 1, 0);
        add(32'h3A1B8000, 0, 0, M_ZLO | M_RIN,  4'd4, 5'd0, 1, 0);
        add(32'h3A1B8000, 0, 0, F0,             4'd0, 5'd0, 1, 0);
        // not R5,R2: 5 cycles
        fetch(32'h92900000);
        add(32'h92900000, 0, 0, M_ROUT | M_ZIN, 4'd2, 5'd18, 1, 0);
        add(32'h92900000, 0, 0, M_ZLO | M_RIN,  4'd5, 5'd0,  1, 0);
        add(32'h92900000, 0, 0, F0,             4'd0, 5'd0,  1, 0);
        // nop
        fetch(32'hD0000000);
        add(32'hD0000000, 0, 0, 16'h0, 4'd0, 5'd0, 1, 0);
        add(32'hD0000000, 0, 0, F0,    4'd0, 5'd0, 1, 0);
        // halt opcode
        fetch(32'hD8000000);
        add(32'hD8000000, 0, 0, 16'h0, 4'd0, 5'd0, 1, 0);
        add(32'hD8000000, 0, 0, 16'h0, 4'd0, 5'd0, 0, 0);
        add(32'hD8000000, 0, 0, 16'h0, 4'd0, 5'd0, 0, 0);
        // illegal opcode 11111
        fetch(32'hF8000000);
        add(32'hF8000000, 0, 0, 16'h0, 4'd0, 5'd0, 1, 0);
        add(32'hF8000000, 0, 0, 16'h0, 4'd0, 5'd0, 0, 1);
        add(32'hF8000000, 0, 0, 16'h0, 4'd0, 5'd0, 0, 1);
        // mul R3,R1,R2
        fetch(32'h79890000);
`ifdef MULDIV_EN
        add(32'h79890000, 0, 0, M_ROUT | M_YIN,  4'd1, 5'd0,  1, 0);
        add(32'h79890000, 0, 0, M_ROUT | M_ZIN,  4'd2, 5'd15, 1, 0);
        add(32'h79890000, 0, 0, M_ZLO | M_LOIN,  4'd0, 5'd0,  1, 0);
        add(32'h79890000, 0, 0, M_ZHI | M_HIIN,  4'd0, 5'd0,  1, 0);
        add(32'h79890000, 0, 0, F0,              4'd0, 5'd0,  1, 0);
`else
        add(32'h79890000, 0, 0, 16'h0, 4'd0, 5'd0, 1, 0);
        add(32'h79890000, 0, 0, 16'h0, 4'd0, 5'd0, 0, 1);
        // div is illegal as well
        fetch(32'h80000000);
        add(32'h80000000, 0, 0, 16'h0, 4'd0, 5'd0, 1, 0);
        add(32'h80000000, 0, 0, 16'h0, 4'd0, 5'd0, 0, 1);
`endif
        // Stop sampled in T0 -> HALT for 10 cycles, clear restores Run
        add(32'h3A1B8000, 1, 1, F0, 4'd0, 5'd0, 1, 0);
        for (int k = 0; k < 10; k++)
            add(32'h3A1B8000, 0, 0, 16'h0, 4'd0, 5'd0, 0, 0);
        add(32'h3A1B8000, 0, 1, F0, 4'd0, 5'd0, 1, 0);
        add(32'h3A1B8000, 0, 0, F1, 4'd0, 5'd0, 1, 0);

        // Reset state while clear is held, including across a clock edge
        #2;
        chk("reset_word", {5'd0, word_act}, {5'd0, 16'h0, 4'd0, 5'd0, 1'b1, 1'b0});
        @(posedge Clock);
        #1;
        chk("reset_held", {5'd0, word_act}, {5'd0, 16'h0, 4'd0, 5'd0, 1'b1, 1'b0});
        clear = 1'b0;

        foreach (vecs[i]) begin
            @(negedge Clock);
            bus.IR   = vecs[i].ir;
            bus.Stop = vecs[i].stop;
            if (vecs[i].clr) begin
                clear = 1'b1;
                #1;
                clear = 1'b0;
            end
            #1;
            chk($sformatf("vec%0d", i), {5'd0, word_act},
                {5'd0, vecs[i].en, vecs[i].rsel, vecs[i].op, vecs[i].run, vecs[i].err});
        end

        // clear mid-T4 of an add: Zin drops immediately, no Rin, restart from T0
        @(negedge Clock);
        bus.IR   = 32'h0A1B8000;
        bus.Stop = 1'b0;
        clear    = 1'b1;
        #1;
        clear    = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        chk("midT4_before", {5'd0, word_act}, {5'd0, M_ROUT | M_ZIN, 4'd7, 5'd1, 1'b1, 1'b0});
        clear = 1'b1;
        #1;
        chk("midT4_zin_drop", {31'd0, bus.Zin}, 32'd0);
        chk("midT4_cleared", {5'd0, word_act}, {5'd0, 16'h0, 4'd0, 5'd0, 1'b1, 1'b0});
        @(posedge Clock);
        #1;
        chk("midT4_no_rin", {30'd0, bus.Rin, bus.PCin}, 32'd0);
        clear = 1'b0;
        #1;
        chk("midT4_t0", {16'd0, en_act}, {16'd0, F0});
        @(posedge Clock);
        #1;
        chk("midT4_t1", {16'd0, en_act}, {16'd0, F1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
